board_io: RTL and testbench
===========================

Name: board_io

Overview:
- Parametrised board I/O peripheral between the sc1 CPU and board pins.
- Replaces direct wiring of the CPU output port to LEDs and the bare two-flop button reset.
- Provides synchronised and debounced push-buttons with sticky press events, LEDs with a global PWM brightness, and a stretched reset output.
- The CPU reaches all of it through a small register interface.

Parameters:
- WIDTH_D, 32: register/data width; must be ≥ max(N_LED, N_BTN, PWM_BITS).
- N_BTN, 4: number of push-button inputs.
- N_LED, 8: number of LED outputs.
- DEBOUNCE_BITS, 16: debounce counter width; DB_MAX = 2^DEBOUNCE_BITS-1.
- PWM_BITS, 8: PWM counter and duty width.
- ACTIVE_LOW_BTN, 1: 1 = a pressed button reads 0 on the pin.
- ACTIVE_LOW_LED, 1: 1 = an LED is lit by driving 0.
- RST_STRETCH, 16: cycles rst_out stays high after reset deasserts.

Ports:
- clk, in, 1: single clock for the whole block.
- reset, in, 1: synchronous, active-high.
- wr_en, in, 1: register write strobe.
- rd_en, in, 1: register read strobe.
- addr, in, 2: register address.
- wr_data, in, WIDTH_D: write data.
- rd_data, out, WIDTH_D: read data, registered.
- btn_in, in, N_BTN: raw asynchronous button pins.
- led_out, out, N_LED: LED pins, pin polarity applied.
- irq, out, 1: registered OR of the event flags.
- rst_out, out, 1: stretched reset for downstream logic.

Behaviour:
- Clocking and reset: clk only. reset is synchronous and active-high.
- Reset values:
  - rd_data=0, irq=0, rst_out=1.
  - led_reg=0, duty=all-ones, evt=0, stable=0 (released), sync flops=0, debounce counters=0, pwm_cnt=0.
  - led_out sits at the inactive level (all-ones when ACTIVE_LOW_LED=1).
- Register map (addr):
  - 0 LED: RW, bits[N_LED-1:0].
  - 1 DUTY: RW, bits[PWM_BITS-1:0].
  - 2 BTN: RO, debounced level, 1=pressed; writes ignored.
  - 3 EVT: read returns sticky press flags; write-1-to-clear.
  - Reads zero-extend to WIDTH_D. Write bits above the field are ignored.
- Read timing:
  - rd_en at edge N puts data on rd_data after edge N; rd_data holds until the next rd_en.
  - Read and write to the same address in one cycle returns the pre-write value.
- Button path, per channel:
  - Polarity-normalise, then 2-flop synchronise to produce sync2.
  - If sync2==stable: counter <= 0.
  - Else if counter==DB_MAX: stable <= sync2 and counter <= 0.
  - Else: counter+1.
  - Latency: a clean level change held steadily updates stable exactly DB_MAX+3 edges after the pin changes.
  - Any sync2 glitch shorter than DB_MAX+1 cycles produces no change.
- Events:
  - A 0→1 transition of stable sets evt[i] on the same edge that stable updates.
  - A write-1-to-clear and a set on the same cycle leave the bit set (set wins).
  - irq = |evt, registered, so it lags evt by one cycle.
  - A button held through reset release is debounced after reset and produces one event.
- PWM:
  - pwm_cnt is free-running over PWM_BITS and wraps from all-ones to 0.
  - led_on[i] = led_reg[i] && (duty==all-ones || pwm_cnt < duty).
  - duty=0 forces the LED off.
  - led_out is registered (one-cycle lag) and inverted when ACTIVE_LOW_LED=1.
- rst_out:
  - High while reset=1.
  - After reset falls, stays high exactly RST_STRETCH further cycles, then 0.
  - Reasserting reset mid-stretch restarts the stretch.
- Reset mid-operation aborts debounce and clears events, with no glitch beyond the reset values listed.

Decomposition:
- Package board_io_pkg: ADDR_LED=0, ADDR_DUTY=1, ADDR_BTN=2, ADDR_EVT=3, and the address-width constant 2.
- Sub-module btn_debounce: one channel, covering the sync flops, counter, stable level and rise pulse. Instantiated N_BTN times in a generate loop.
- The PWM, register file and reset stretcher stay in board_io.

Test Plan (all scenarios use DEBOUNCE_BITS=4, PWM_BITS=4, RST_STRETCH=4, active-low pins):
- Reset: hold reset 3 cycles, then release → rst_out=1 for 4 cycles after release, then 0. led_out=0xFF; rd_data, irq and evt all 0.
- Debounce:
  - Drive btn_in[0] 1→0 and hold → BTN reads 0x1 and evt[0]=1 exactly 18 edges after the pin change; irq=1 one cycle later.
  - A 10-cycle low glitch → BTN stays 0x0 and no event.
- Event clear:
  - Write EVT=0x1 → evt=0 and irq drops one cycle later.
  - Write EVT=0x1 on the same cycle as a new btn1 press → evt reads 0x2, and a repeat press of btn0 leaves evt[0] set.
- PWM:
  - Write LED=0x05, DUTY=4 → led_out[0] and led_out[2] low for 4 of every 16 cycles; other bits constantly 1.
  - DUTY=15 → bits 0 and 2 constantly 0; DUTY=0 → all bits constantly 1.
- Read/write collision: write LED=0xA5 with rd_en on addr 0 in the same cycle → rd_data=old value (0x00); next read returns 0xA5.
- Mid-operation reset: assert reset during a debounce count and with evt=0x3 → evt=0 and counters cleared; a still-held button re-debounces and produces a single event 18 edges after reset release.

Source files
------------

// File: rtl/board_io_pkg.sv
// Shared register-map constants for the board_io peripheral.
package board_io_pkg;

  localparam int ADDR_W = 2;

  localparam logic [ADDR_W-1:0] ADDR_LED  = 2'd0;
  localparam logic [ADDR_W-1:0] ADDR_DUTY = 2'd1;
  localparam logic [ADDR_W-1:0] ADDR_BTN  = 2'd2;
  localparam logic [ADDR_W-1:0] ADDR_EVT  = 2'd3;

endpackage

// File: rtl/board_io_btn_debounce.sv
// One push-button channel: polarity normalise, 2-flop sync, debounce counter,
// stable level and a single-cycle press pulse coincident with the level update.
module btn_debounce
  import board_io_pkg::*;
#(
  parameter int DEBOUNCE_BITS = 16,
  parameter bit ACTIVE_LOW    = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_pin,
  output logic level,
  output logic rise
);

  localparam logic [DEBOUNCE_BITS-1:0] DB_MAX = '1;

  logic                     sync1_q, sync1_d;
  logic                     sync2_q, sync2_d;
  logic                     stable_q, stable_d;
  logic [DEBOUNCE_BITS-1:0] cnt_q, cnt_d;

  always_comb begin
    sync1_d  = btn_pin ^ ACTIVE_LOW;
    sync2_d  = sync1_q;
    stable_d = stable_q;
    cnt_d    = cnt_q;
    rise     = 1'b0;
    if (sync2_q == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == DB_MAX) begin
      stable_d = sync2_q;
      cnt_d    = '0;
      rise     = sync2_q;
    end else begin
      cnt_d = cnt_q + DEBOUNCE_BITS'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign level = stable_q;

endmodule

// File: rtl/board_io.sv
// Board I/O peripheral: debounced buttons with sticky press events, PWM-dimmed
// LEDs, stretched reset output, all behind a 4-entry register file.
module board_io
  import board_io_pkg::*;
#(
  parameter int WIDTH_D        = 32,
  parameter int N_BTN          = 4,
  parameter int N_LED          = 8,
  parameter int DEBOUNCE_BITS  = 16,
  parameter int PWM_BITS       = 8,
  parameter int ACTIVE_LOW_BTN = 1,
  parameter int ACTIVE_LOW_LED = 1,
  parameter int RST_STRETCH    = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               wr_en,
  input  logic               rd_en,
  input  logic [ADDR_W-1:0]  addr,
  input  logic [WIDTH_D-1:0] wr_data,
  output logic [WIDTH_D-1:0] rd_data,
  input  logic [N_BTN-1:0]   btn_in,
  output logic [N_LED-1:0]   led_out,
  output logic               irq,
  output logic               rst_out
);

  localparam logic [PWM_BITS-1:0] DUTY_MAX = '1;
  localparam bit                  LED_INV  = (ACTIVE_LOW_LED != 0);
  localparam int                  RST_CW   = $clog2(RST_STRETCH + 2);
  localparam logic [RST_CW-1:0]   RST_LOAD = RST_CW'(RST_STRETCH);

  logic [N_BTN-1:0] btn_level;
  logic [N_BTN-1:0] btn_rise;

  for (genvar i = 0; i < N_BTN; i++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_BITS (DEBOUNCE_BITS),
      .ACTIVE_LOW    (ACTIVE_LOW_BTN != 0)
    ) u_btn (
      .clk     (clk),
      .reset   (reset),
      .btn_pin (btn_in[i]),
      .level   (btn_level[i]),
      .rise    (btn_rise[i])
    );
  end

  logic [N_LED-1:0]   led_reg_q, led_reg_d;
  logic [PWM_BITS-1:0] duty_q, duty_d;
  logic [N_BTN-1:0]   evt_q, evt_d;
  logic               irq_q, irq_d;
  logic [WIDTH_D-1:0] rd_data_q, rd_data_d;
  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [N_LED-1:0]   led_out_q, led_out_d;
  logic [RST_CW-1:0]  rst_cnt_q, rst_cnt_d;
  logic               rst_out_q, rst_out_d;
  logic [N_BTN-1:0]   evt_clr;
  logic [N_LED-1:0]   led_on;
  logic               unused_wr;

  assign unused_wr = ^wr_data;

  always_comb begin
    led_reg_d = led_reg_q;
    duty_d    = duty_q;
    evt_clr   = '0;
    rd_data_d = rd_data_q;

    if (wr_en) begin
      case (addr)
        ADDR_LED:  led_reg_d = wr_data[N_LED-1:0];
        ADDR_DUTY: duty_d    = wr_data[PWM_BITS-1:0];
        ADDR_EVT:  evt_clr   = wr_data[N_BTN-1:0];
        default:   ;
      endcase
    end

    // A press arriving on the same edge as its clear must not be lost.
    evt_d = (evt_q & ~evt_clr) | btn_rise;
    irq_d = |evt_q;

    if (rd_en) begin
      rd_data_d = '0;
      case (addr)
        ADDR_LED:  rd_data_d[N_LED-1:0]    = led_reg_q;
        ADDR_DUTY: rd_data_d[PWM_BITS-1:0] = duty_q;
        ADDR_BTN:  rd_data_d[N_BTN-1:0]    = btn_level;
        ADDR_EVT:  rd_data_d[N_BTN-1:0]    = evt_q;
        default:   ;
      endcase
    end

    pwm_cnt_d = pwm_cnt_q + PWM_BITS'(1);
    led_on    = led_reg_q & {N_LED{(duty_q == DUTY_MAX) || (pwm_cnt_q < duty_q)}};
    led_out_d = led_on ^ {N_LED{LED_INV}};

    rst_cnt_d = (rst_cnt_q != '0) ? rst_cnt_q - RST_CW'(1) : '0;
    rst_out_d = (rst_cnt_q != '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      led_reg_q <= '0;
      duty_q    <= DUTY_MAX;
      evt_q     <= '0;
      irq_q     <= 1'b0;
      rd_data_q <= '0;
      pwm_cnt_q <= '0;
      led_out_q <= {N_LED{LED_INV}};
      rst_cnt_q <= RST_LOAD;
      rst_out_q <= 1'b1;
    end else begin
      led_reg_q <= led_reg_d;
      duty_q    <= duty_d;
      evt_q     <= evt_d;
      irq_q     <= irq_d;
      rd_data_q <= rd_data_d;
      pwm_cnt_q <= pwm_cnt_d;
      led_out_q <= led_out_d;
      rst_cnt_q <= rst_cnt_d;
      rst_out_q <= rst_out_d;
    end
  end

  assign rd_data = rd_data_q;
  assign led_out = led_out_q;
  assign irq     = irq_q;
  assign rst_out = rst_out_q;

endmodule

// File: tb/tb_board_io.sv
// Self-checking bench for board_io with short debounce, PWM and stretch settings.
module tb_board_io;
  import board_io_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_en;
  logic        rd_en;
  logic [1:0]  addr;
  logic [31:0] wr_data;
  logic [31:0] rd_data;
  logic [3:0]  btn_in;
  logic [7:0]  led_out;
  logic        irq;
  logic        rst_out;

  int total = 0;
  int bad   = 0;

  logic [31:0] exp_q[$];
  string       tag_q[$];

  board_io #(
    .WIDTH_D        (32),
    .N_BTN          (4),
    .N_LED          (8),
    .DEBOUNCE_BITS  (4),
    .PWM_BITS       (4),
    .ACTIVE_LOW_BTN (1),
    .ACTIVE_LOW_LED (1),
    .RST_STRETCH    (4)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en),
    .rd_en   (rd_en),
    .addr    (addr),
    .wr_data (wr_data),
    .rd_data (rd_data),
    .btn_in  (btn_in),
    .led_out (led_out),
    .irq     (irq),
    .rst_out (rst_out)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: sim time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h want=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic pop_check();
    logic [31:0] e;
    string       t;
    if (exp_q.size() == 0) begin
      check_val("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      check_val(t, rd_data, e);
    end
  endtask

  task automatic rd_cycle(input logic [1:0] a, input logic [31:0] exp, input string tag);
    addr  = a;
    rd_en = 1'b1;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    tick();
    rd_en = 1'b0;
    pop_check();
  endtask

  task automatic wr_reg(input logic [1:0] a, input logic [31:0] d);
    addr    = a;
    wr_data = d;
    wr_en   = 1'b1;
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic pwm_window(input string tag, input int exp_lows);
    int lows0, lows2, others_bad;
    lows0 = 0; lows2 = 0; others_bad = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (!led_out[0]) lows0++;
      if (!led_out[2]) lows2++;
      if ((led_out & 8'hFA) != 8'hFA) others_bad++;
    end
    check_val({tag, "_b0"}, lows0, exp_lows);
    check_val({tag, "_b2"}, lows2, exp_lows);
    check_val({tag, "_other"}, others_bad, 0);
  endtask

  initial begin
    reset   = 1'b1;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    addr    = 2'd0;
    wr_data = 32'd0;
    btn_in  = 4'hF;

    ticks(3);
    check_val("rst_rst_out", rst_out, 1);
    check_val("rst_led_out", led_out, 8'hFF);
    check_val("rst_rd_data", rd_data, 0);
    check_val("rst_irq", irq, 0);
    reset = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      tick();
      check_val($sformatf("stretch_%0d", k), rst_out, (k <= 4) ? 1 : 0);
    end
    check_val("rst_led_idle", led_out, 8'hFF);
    rd_cycle(ADDR_EVT, 32'h0, "rst_evt");
    rd_cycle(ADDR_DUTY, 32'hF, "rst_duty");
    rd_cycle(ADDR_LED, 32'h0, "rst_led");

    // btn0 press: level visible in BTN read at edge 19 => stable updated at edge 18
    tick();
    btn_in = 4'b1110;
    for (int k = 1; k <= 19; k++) begin
      rd_cycle(ADDR_BTN, (k == 19) ? 32'h1 : 32'h0, $sformatf("db_btn_%0d", k));
      check_val($sformatf("db_irq_%0d", k), irq, (k == 19) ? 1 : 0);
    end
    rd_cycle(ADDR_EVT, 32'h1, "db_evt");

    tick();
    btn_in = 4'b1100;
    ticks(10);
    btn_in = 4'b1110;
    ticks(25);
    rd_cycle(ADDR_BTN, 32'h1, "glitch_btn");
    rd_cycle(ADDR_EVT, 32'h1, "glitch_evt");

    wr_reg(ADDR_EVT, 32'h1);
    check_val("clr_irq_lag", irq, 1);
    tick();
    check_val("clr_irq_low", irq, 0);
    rd_cycle(ADDR_EVT, 32'h0, "clr_evt");

    // btn1 press whose event lands on the very edge of a clear write
    tick();
    btn_in = 4'b1100;
    ticks(17);
    wr_reg(ADDR_EVT, 32'h3);
    rd_cycle(ADDR_EVT, 32'h2, "setwins_evt");
    rd_cycle(ADDR_BTN, 32'h3, "setwins_btn");

    btn_in = 4'b1101;
    ticks(22);
    rd_cycle(ADDR_EVT, 32'h2, "release_evt");
    rd_cycle(ADDR_BTN, 32'h2, "release_btn");
    btn_in = 4'b1100;
    ticks(22);
    rd_cycle(ADDR_EVT, 32'h3, "repress_evt");
    btn_in = 4'b1101;
    ticks(22);
    btn_in = 4'b1100;
    ticks(22);
    rd_cycle(ADDR_EVT, 32'h3, "repress2_evt");

    wr_reg(ADDR_LED, 32'h05);
    wr_reg(ADDR_DUTY, 32'h4);
    tick();
    pwm_window("pwm4", 4);
    wr_reg(ADDR_DUTY, 32'hF);
    tick();
    pwm_window("pwm15", 16);
    wr_reg(ADDR_DUTY, 32'h0);
    tick();
    pwm_window("pwm0", 0);

    // reset in the middle of a btn1 release count with evt=0x3
    btn_in = 4'b1110;
    ticks(8);
    reset = 1'b1;
    ticks(2);
    check_val("mid_rst_out", rst_out, 1);
    check_val("mid_irq", irq, 0);
    reset = 1'b0;
    for (int k = 1; k <= 19; k++) begin
      rd_cycle(ADDR_EVT, (k == 19) ? 32'h1 : 32'h0, $sformatf("mid_evt_%0d", k));
      check_val($sformatf("mid_stretch_%0d", k), rst_out, (k <= 4) ? 1 : 0);
      check_val($sformatf("mid_irq_%0d", k), irq, (k == 19) ? 1 : 0);
    end
    ticks(5);
    rd_cycle(ADDR_EVT, 32'h1, "mid_single_evt");
    rd_cycle(ADDR_BTN, 32'h1, "mid_btn");
    check_val("mid_led_off", led_out, 8'hFF);

    addr    = ADDR_LED;
    wr_data = 32'hA5;
    wr_en   = 1'b1;
    rd_en   = 1'b1;
    exp_q.push_back(32'h0);
    tag_q.push_back("rw_same_old");
    tick();
    wr_en = 1'b0;
    rd_en = 1'b0;
    pop_check();
    rd_cycle(ADDR_LED, 32'hA5, "rw_next_new");
    rd_cycle(ADDR_DUTY, 32'hF, "mid_duty_reset");
    wr_reg(ADDR_LED, 32'hFFFFFF5A);
    rd_cycle(ADDR_LED, 32'h5A, "led_upper_ignored");
    wr_reg(ADDR_BTN, 32'hF);
    rd_cycle(ADDR_BTN, 32'h1, "btn_ro");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
